// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
//   Time-multiplexed seven-segment scanner. Each rising edge of the display
//   refresh wave (disp_tick) steps to the next digit. Digit data and masks are
//   snapshotted once per frame so the display never tears. Every digit change
//   is followed by a dead time with all anodes off, to suppress ghosting.
//   Digits can be blanked or made to blink individually.
// Ports
//   clk, rstn     system clock, asynchronous active-low reset
//   disp_tick     refresh square wave (already in the clk domain)
//   digits        hex nibbles, digits[3:0] is digit 0
//   dp_mask       1 = decimal point lit for that digit
//   blank_mask    1 = digit dark
//   blink_mask    1 = digit blinks with the frame-based blink phase
//   an            anodes, active-low (one low while lit, all high when dark)
//   seg           segments {g,f,e,d,c,b,a}, active-low
//   dp            decimal point, active-low
//   frame_start   single-cycle pulse, one cycle after each shadow load
module seg7_scan_ctrl #(
  parameter int NDIG         = 4,
  parameter int DEAD_CYC     = 16,
  parameter int BLINK_FRAMES = 250
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              disp_tick,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp_mask,
  input  logic [NDIG-1:0]   blank_mask,
  input  logic [NDIG-1:0]   blink_mask,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_start
);

  localparam int IW = $clog2(NDIG);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {S_LOAD, S_DEAD, S_ON} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [DW-1:0]          dead_cnt, dead_nxt;
  logic [FW-1:0]          frame_cnt;
  logic                   blink_phase;
  logic                   tick_q, tick_rise;
  logic                   load;
  logic [NDIG-1:0][3:0]   dig_sh;
  logic [NDIG-1:0]        dp_sh, blank_sh, blink_sh;
  logic                   lit;

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] dec7(input logic [3:0] h);
    case (h)
      4'h0: dec7 = 7'h40;  4'h1: dec7 = 7'h79;
      4'h2: dec7 = 7'h24;  4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19;  4'h5: dec7 = 7'h12;
      4'h6: dec7 = 7'h02;  4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00;  4'h9: dec7 = 7'h10;
      4'hA: dec7 = 7'h08;  4'hB: dec7 = 7'h03;
      4'hC: dec7 = 7'h46;  4'hD: dec7 = 7'h21;
      4'hE: dec7 = 7'h06;  default: dec7 = 7'h0E;
    endcase
  endfunction

  // A level held high produces exactly one step.
  assign tick_rise = disp_tick & ~tick_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dead_nxt  = dead_cnt;
    load      = 1'b0;
    case (state)
      S_LOAD: begin
        load      = 1'b1;
        dead_nxt  = '0;
        state_nxt = S_DEAD;
      end
      S_DEAD: begin
        dead_nxt = dead_cnt + DW'(1);
        if (dead_cnt == DW'(DEAD_CYC - 1)) state_nxt = S_ON;
      end
      default: ;
    endcase
    // A refresh edge overrides the dead-time exit; it is dropped during the
    // one-cycle load so a frame always starts from a clean snapshot.
    if (tick_rise && state != S_LOAD) begin
      if (idx == IW'(NDIG - 1)) begin
        idx_nxt   = '0;
        state_nxt = S_LOAD;
      end else begin
        idx_nxt   = idx + IW'(1);
        dead_nxt  = '0;
        state_nxt = S_DEAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_q      <= 1'b0;
      idx         <= '0;
      dead_cnt    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      dig_sh      <= '0;
      dp_sh       <= '0;
      blank_sh    <= '0;
      blink_sh    <= '0;
    end else begin
      tick_q   <= disp_tick;
      idx      <= idx_nxt;
      dead_cnt <= dead_nxt;
      if (load) begin
        dig_sh   <= digits;
        dp_sh    <= dp_mask;
        blank_sh <= blank_mask;
        blink_sh <= blink_mask;
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  assign lit = (state == S_ON) & ~blank_sh[idx] & ~(blink_sh[idx] & blink_phase);

  // Registered outputs: glitch-free pins, one cycle behind the FSM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= lit ? ~(NDIG'(1) << idx) : '1;
      seg         <= lit ? dec7(dig_sh[idx]) : 7'h7F;
      dp          <= lit ? ~dp_sh[idx] : 1'b1;
      frame_start <= (state == S_LOAD);
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
//   Scoreboard bench for seg7_scan_ctrl (NDIG=4, DEAD_CYC=16, BLINK_FRAMES=2).
//   Stimulus pushes the expected lit digit (anodes, segments, dp, dark gap)
//   for every scan slot; a negedge monitor pops one entry each time the
//   display goes from dark to lit and also checks dark/lit invariants.
module tb_seg7_scan_ctrl;
  localparam int NDIG = 4;
  localparam int DEAD = 16;
  localparam int BF   = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        disp_tick = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0, blank_mask = '0, blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, frame_start;

  seg7_scan_ctrl #(.NDIG(NDIG), .DEAD_CYC(DEAD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rstn(rstn), .disp_tick(disp_tick), .digits(digits),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .blink_mask(blink_mask),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         gap;   // expected dark cycles before this digit, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: dec = 7'h40;  4'h1: dec = 7'h79;  4'h2: dec = 7'h24;  4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;  4'h5: dec = 7'h12;  4'h6: dec = 7'h02;  4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;  4'h9: dec = 7'h10;  4'hA: dec = 7'h08;  4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;  4'hD: dec = 7'h21;  4'hE: dec = 7'h06;  default: dec = 7'h0E;
    endcase
  endfunction

  // ---------------- monitor ----------------
  int         dcnt = 0;
  int         fs_cnt = 0;
  logic       prev_lit = 1'b0;
  logic       p_fs = 1'b0;
  logic [3:0] p_an = '1;
  logic [6:0] p_seg = 7'h7F;
  logic       p_dp = 1'b1;
  exp_t       e;

  always @(negedge clk) begin
    if (!rstn) begin
      dcnt     = 0;
      prev_lit = 1'b0;
      p_fs     = 1'b0;
    end else begin
      if (frame_start) begin
        fs_cnt++;
        chk("frame_start_width", 32'(p_fs), 32'(1'b0));
      end
      p_fs = frame_start;
      if (an == 4'hF) begin
        chk("dark_seg_dp", 32'({seg, dp}), 32'(8'hFF));
        dcnt++;
        prev_lit = 1'b0;
      end else begin
        chk("an_onehot", 32'($countones(~an)), 32'(1));
        if (prev_lit) begin
          chk("lit_stable", 32'({an, seg, dp}), 32'({p_an, p_seg, p_dp}));
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_lit actual an=%b seg=%h dp=%b required=dark", an, seg, dp);
        end else begin
          e = exp_q.pop_front();
          chk("lit_an", 32'(an), 32'(e.an));
          chk("lit_seg", 32'(seg), 32'(e.seg));
          chk("lit_dp", 32'(dp), 32'(e.dp));
          if (e.gap != 0) chk("dead_gap", 32'(dcnt), 32'(e.gap));
        end
        prev_lit = 1'b1;
        p_an = an; p_seg = seg; p_dp = dp;
        dcnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] m_dig;
  logic [3:0]  m_dp, m_bk, m_bl;
  int          m_fcnt = 0, m_phase = 0, m_loads = 0;
  bit          m_prev = 1'b0;

  task automatic model_reset();
    m_fcnt = 0; m_phase = 0; m_prev = 1'b0;
  endtask

  task automatic model_load();
    m_dig = digits; m_dp = dp_mask; m_bk = blank_mask; m_bl = blink_mask;
    m_loads++;
    if (m_fcnt == BF - 1) begin
      m_fcnt = 0;
      m_phase = 1 - m_phase;
    end else begin
      m_fcnt++;
    end
  endtask

  task automatic push_slot(input int d, input int g);
    exp_t x;
    logic [3:0] one;
    bit lit;
    one = 4'b0001;
    lit = !m_bk[d] && !(m_bl[d] && m_phase != 0);
    if (lit) begin
      x.an  = ~(one << d);
      x.seg = dec(m_dig[d*4 +: 4]);
      x.dp  = ~m_dp[d];
      x.gap = m_prev ? g : 0;
      exp_q.push_back(x);
    end
    m_prev = lit;
  endtask

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic rise();
    disp_tick = 1'b1;
    repeat (100) step();
    disp_tick = 1'b0;
    repeat (100) step();
  endtask

  // The rise moves the scan into slot d; slot 0 begins a new frame.
  task automatic slot(input int d);
    if (d == 0) model_load();
    push_slot(d, (d == 0) ? DEAD + 1 : DEAD);
    rise();
  endtask

  task automatic frame();
    for (int d = 0; d < NDIG; d++) slot(d);
  endtask

  initial begin
    // T1: reset holds everything dark regardless of inputs
    digits = 16'h5A5A; dp_mask = 4'hF; blink_mask = 4'h3;
    for (int i = 0; i < 5; i++) begin
      disp_tick = ~disp_tick;
      step();
      chk("reset_an", 32'(an), 32'(4'hF));
      chk("reset_seg", 32'(seg), 32'(7'h7F));
      chk("reset_dp", 32'(dp), 32'(1'b1));
      chk("reset_fs", 32'(frame_start), 32'(1'b0));
    end

    // T2: startup
    digits = 16'h1234; dp_mask = '0; blank_mask = '0; blink_mask = '0; disp_tick = 1'b0;
    model_reset();
    model_load();
    m_prev = 1'b1;
    push_slot(0, DEAD + 2);
    step();
    rstn = 1'b1;
    step();
    chk("start_fs", 32'(frame_start), 32'(1'b1));
    chk("start_dark", 32'(an), 32'(4'hF));
    repeat (16) step();
    chk("start_dark_e17", 32'(an), 32'(4'hF));
    step();
    chk("start_an", 32'(an), 32'(4'b1110));
    chk("start_seg", 32'(seg), 32'(7'h19));

    // T3: plain scanning
    slot(1); slot(2); slot(3);
    frame();
    chk("t3_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("t3_frames", 32'(fs_cnt), 32'(m_loads));

    // T4: data change mid-frame only shows from the next frame
    slot(0); slot(1); slot(2);
    digits = 16'hABCD;
    slot(3);
    frame();
    chk("t4_queue_empty", 32'(exp_q.size()), 32'(0));

    // T5: blank, blink and decimal point
    blank_mask = 4'b0010; blink_mask = 4'b0001; dp_mask = 4'b1000;
    repeat (4) frame();
    chk("t5_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("t5_frames", 32'(fs_cnt), 32'(m_loads));

    // T6a: long high level advances once
    blank_mask = '0; blink_mask = '0; dp_mask = '0;
    model_load();
    push_slot(0, DEAD + 1);
    disp_tick = 1'b1;
    repeat (1000) step();
    disp_tick = 1'b0;
    repeat (100) step();
    chk("t6_hold_single", 32'(exp_q.size()), 32'(0));
    chk("t6_hold_an", 32'(an), 32'(4'b1110));
    slot(1);

    // T6b: reset mid-frame, with a rise during the load cycle
    rstn = 1'b0;
    #1;
    chk("t6_rst_an", 32'(an), 32'(4'hF));
    chk("t6_rst_seg", 32'(seg), 32'(7'h7F));
    chk("t6_rst_dp", 32'(dp), 32'(1'b1));
    chk("t6_rst_fs", 32'(frame_start), 32'(1'b0));
    disp_tick = 1'b1;
    step(); step();
    model_reset();
    model_load();
    m_prev = 1'b1;
    push_slot(0, DEAD + 2);
    rstn = 1'b1;
    step();
    chk("t6_restart_fs", 32'(frame_start), 32'(1'b1));
    repeat (17) step();
    chk("t6_restart_an", 32'(an), 32'(4'b1110));
    chk("t6_restart_seg", 32'(seg), 32'(7'h21));
    repeat (300) step();
    chk("t6_load_rise_ignored", 32'(an), 32'(4'b1110));
    disp_tick = 1'b0;
    repeat (50) step();
    slot(1);

    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("final_frames", 32'(fs_cnt), 32'(m_loads));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
